// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC select codes and fetch FSM states.
package pc_fetch_unit_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    typedef enum logic [1:0] {
        FETCH_S = 2'd0,
        WAIT_S  = 2'd1,
        ISSUE_S = 2'd2,
        HALT_S  = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/grant/response channel between the fetch unit and imem.
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection for the retiring instruction, plus alignment check.
module npc_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  NPCOp,
    input  logic        br_taken,
    input  logic [31:0] immout,
    input  logic [31:0] rs1_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc_rel;
    logic [31:0] reg_rel;

    assign pc_rel  = pc + immout;
    assign reg_rel = rs1_data + immout;

    // NOTE: every output of an always_comb gets a default first so no path infers a latch.
    always_comb begin
        next_pc = pc + 32'd4;
        case (NPCOp)
            NPC_BRANCH: if (br_taken) next_pc = pc_rel;
            NPC_JUMP:   next_pc = pc_rel;
            NPC_JALR:   next_pc = {reg_rel[31:1], 1'b0};
            default:    next_pc = pc + 32'd4;
        endcase
    end

    // Checked after the JALR bit-0 clear, so only bit 1 can trip it for JALR.
    assign misaligned = !is_word_aligned(next_pc);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch FSM: fetch at pc, hold the word until retire, then advance.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    pc_fetch_unit_if.master        imem,
    output logic                   instr_valid,
    output logic [31:0]            instr,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    input  logic                   retire,
    input  logic [2:0]             NPCOp,
    input  logic                   br_taken,
    input  logic [31:0]            immout,
    input  logic [31:0]            rs1_data,
    output logic                   misalign_exc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  next_pc;
    logic         misaligned;

    npc_calc u_npc_calc (
        .pc         (pc_q),
        .NPCOp      (NPCOp),
        .br_taken   (br_taken),
        .immout     (immout),
        .rs1_data   (rs1_data),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH_S;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        imem.imem_req = 1'b0;
        case (state_q)
            FETCH_S: begin
                imem.imem_req = 1'b1;
                if (imem.imem_gnt) state_d = WAIT_S;
            end
            WAIT_S:  if (imem.imem_rvalid) state_d = ISSUE_S;
            ISSUE_S: if (retire) state_d = misaligned ? HALT_S : FETCH_S;
            HALT_S:  state_d = HALT_S;
            default: state_d = FETCH_S;
        endcase
    end

    // A misaligned target leaves pc pointing at the faulting instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            if (state_q == WAIT_S && imem.imem_rvalid) instr_q <= imem.imem_rdata;
            if (state_q == ISSUE_S && retire && !misaligned) pc_q <= next_pc;
        end
    end

    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == ISSUE_S);
    assign misalign_exc   = (state_q == HALT_S);

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage; the downstream consumer of the immediate generator's immout, and the source of the instruction that is later decoded into immediate fields.
- Holds the architectural PC and fetches the instruction at that PC over a request/grant/response handshake to instruction memory.
- Presents that instruction until the core retires it, then computes the next PC (PC+4, branch, JAL, JALR) from the retiring instruction's control signals and immout.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; imem_addr valid while high.
- imem_addr  out  32  fetch address, always equal to pc.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid; earliest one cycle after grant.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr is valid and awaiting retire.
- instr  out  32  held instruction word.
- pc  out  32  address of the held or fetching instruction.
- pc_plus4  out  32  pc+4, combinational, used as the JAL/JALR link value.
- retire  in  1  core consumes the instruction; control inputs sampled this cycle.
- NPCOp  in  3  next-PC select, encoded per ctrl_encode_def.v.
- br_taken  in  1  branch condition result, used only when NPCOp selects BRANCH.
- immout  in  32  extended immediate for the retiring instruction.
- rs1_data  in  32  JALR base register value.
- misalign_exc  out  1  next-PC target not 4-byte aligned; fetch halted.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, misalign_exc=0. imem_req=1 in the first cycle after reset.
- Reset mid-operation (any state) has the same effect. imem shares rst and drops in-flight responses. imem_rvalid is ignored in every state except WAIT.
- FSM states: FETCH, WAIT, ISSUE, HALT.
- FETCH: imem_req=1, imem_addr=pc. Moves to WAIT on imem_gnt, otherwise stays in FETCH.
- WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_valid<=1, move to ISSUE. Otherwise stays in WAIT with no timeout.
- ISSUE: instr_valid=1, instr stable. On retire: compute next PC, instr_valid<=0.
  - Next PC aligned: pc<=next PC, move to FETCH.
  - Next PC misaligned: pc unchanged, misalign_exc<=1, move to HALT.
- retire outside ISSUE has no effect.
- HALT: imem_req=0, instr_valid=0, misalign_exc held at 1. Left only by rst.
- Next-PC rules (all sums modulo 2^32, wrap silently):
  - PLUS4: pc+4.
  - BRANCH: br_taken ? pc+immout : pc+4.
  - JUMP (JAL): pc+immout.
  - JALR: (rs1_data+immout) with bit0 cleared.
  - Any other encoding: pc+4.
- Misaligned means next-PC bits [1:0] != 0, checked after the JALR bit0 clear.
- Minimum latency per instruction: 3 cycles (grant in FETCH, rvalid in the first WAIT cycle, retire in the first ISSUE cycle).
- pc changes only on a retire transition out of ISSUE.

Decomposition:
- ctrl_encode_def.v holds:
  - NPC_PLUS4=3'b000, NPC_BRANCH=3'b001, NPC_JUMP=3'b010, NPC_JALR=3'b100.
  - Fetch-state encodings FETCH_S, WAIT_S, ISSUE_S, HALT_S.
- One combinational sub-module, npc_calc (inputs pc, NPCOp, br_taken, immout, rs1_data; outputs next_pc and misaligned), instantiated inside pc_fetch_unit.

Test Plan:
- Reset, gnt=1, rvalid one cycle later with rdata=0x00500093 -> imem_addr=0x0 on the first post-reset cycle; instr=0x00500093 and instr_valid=1 from the third cycle; pc=0.
- Two PLUS4 retires; second fetch with gnt delayed 2 cycles and rvalid delayed 3 cycles -> addresses 0x0, 0x4, 0x8; imem_req held through the delay; instr_valid=0 while waiting.
- BRANCH at pc=0x10, immout=0xFFFFFFF8, br_taken=1 -> next fetch 0x08. Same with br_taken=0 -> 0x14.
- JUMP at pc=0xFFFFFFFC, immout=0x8 -> fetch 0x00000004 (wrap). JALR with rs1=0x101, imm=0x3 -> fetch 0x104.
- JALR with rs1=0x100, imm=0x2 -> misalign_exc=1, pc stays, imem_req=0 until rst. Then rst -> misalign_exc=0, fetch RESET_PC.
- rst asserted in WAIT with a stale rvalid one cycle later -> stale data not latched; fresh fetch at RESET_PC; instr_valid=0 until the new response.
